// File: rtl/bagua_pkg.sv
// rtl/bagua_pkg.sv - shared types and trigram tables for the yin-yang receiver
// Purpose: FSM state enum, lock-count default and the fixed trigram<->index
// mapping (decode and its encoder inverse) used by the receiver slice.
// Ports: none (package).
package bagua_pkg;

  localparam int LOCK_CNT_DEF = 4;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_TRACK   = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_SUSPECT = 2'd3
  } state_t;

  // bit0 = bottom line, 1 = yang
  function automatic logic [2:0] trigram_decode(input logic [2:0] p);
    logic [2:0] idx;
    case (p)
      3'b111:  idx = 3'd0;
      3'b011:  idx = 3'd1;
      3'b101:  idx = 3'd2;
      3'b001:  idx = 3'd3;
      3'b110:  idx = 3'd4;
      3'b010:  idx = 3'd5;
      3'b100:  idx = 3'd6;
      default: idx = 3'd7;
    endcase
    return idx;
  endfunction

  function automatic logic [2:0] trigram_encode(input logic [2:0] idx);
    logic [2:0] p;
    case (idx)
      3'd0:    p = 3'b111;
      3'd1:    p = 3'b011;
      3'd2:    p = 3'b101;
      3'd3:    p = 3'b001;
      3'd4:    p = 3'b110;
      3'd5:    p = 3'b010;
      3'd6:    p = 3'b100;
      default: p = 3'b000;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/bagua_trigram_dec.sv
// rtl/bagua_trigram_dec.sv - combinational trigram to octal index decoder
// Purpose: maps a 3-line yin-yang trigram to its octal index.
// Ports: trigram [2:0] in (bit0 = bottom line), idx [2:0] out.
module bagua_trigram_dec
  import bagua_pkg::*;
(
  input  logic [2:0] trigram,
  output logic [2:0] idx
);

  assign idx = trigram_decode(trigram);

endmodule

// File: rtl/bagua_yinyang_rx.sv
// rtl/bagua_yinyang_rx.sv - trigram stream receiver with sequence lock tracking
// Purpose: decodes strobed trigrams, tracks the expected +1 mod 8 sequence,
// declares lock after LOCK_CNT consecutive steps and flywheels over one miss.
// Ports: clk, rst_n (sync active-low), en (sample strobe), P_in [2:0] trigram;
//        Q_out [2:0] decoded index, q_valid / err / wrap one-cycle pulses,
//        lock (LOCKED or SUSPECT), err_cnt [ERR_W-1:0] saturating error count.
module bagua_yinyang_rx
  import bagua_pkg::*;
#(
  parameter int LOCK_CNT = LOCK_CNT_DEF,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       P_in,
  output logic [2:0]       Q_out,
  output logic             q_valid,
  output logic             lock,
  output logic             err,
  output logic             wrap,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int RUN_W = $clog2(LOCK_CNT + 1);
  localparam logic [RUN_W-1:0] LOCK_RUN = RUN_W'(LOCK_CNT);
  localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);

  state_t           state, state_nxt;
  logic [RUN_W-1:0] run, run_nxt, run_inc;
  logic [2:0]       ref_idx, ref_nxt, exp_idx, dec_idx;
  logic             match, err_hit, wrap_hit;

  bagua_trigram_dec u_dec (
    .trigram (P_in),
    .idx     (dec_idx)
  );

  // 3-bit addition wraps 7 -> 0 on its own
  assign exp_idx = ref_idx + 3'd1;
  assign match   = (dec_idx == exp_idx);
  assign run_inc = run + RUN_ONE;
  assign lock    = (state == ST_LOCKED) || (state == ST_SUSPECT);

  always_comb begin
    state_nxt = state;
    run_nxt   = run;
    ref_nxt   = ref_idx;
    err_hit   = 1'b0;
    wrap_hit  = 1'b0;
    if (en) begin
      case (state)
        ST_HUNT: begin
          ref_nxt   = dec_idx;
          run_nxt   = RUN_ONE;
          state_nxt = ST_TRACK;
        end
        ST_TRACK: begin
          ref_nxt = dec_idx;
          if (match) begin
            run_nxt = run_inc;
            if (run_inc >= LOCK_RUN) state_nxt = ST_LOCKED;
          end else begin
            run_nxt = RUN_ONE;
          end
        end
        ST_LOCKED: begin
          if (match) begin
            ref_nxt  = dec_idx;
            wrap_hit = (exp_idx == 3'd0);
          end else begin
            // flywheel: assume the sample was corrupted and step anyway
            err_hit   = 1'b1;
            ref_nxt   = exp_idx;
            state_nxt = ST_SUSPECT;
          end
        end
        default: begin
          if (match) begin
            ref_nxt   = dec_idx;
            wrap_hit  = (exp_idx == 3'd0);
            state_nxt = ST_LOCKED;
          end else begin
            // two misses in a row: trust the line again and re-acquire
            err_hit   = 1'b1;
            ref_nxt   = dec_idx;
            run_nxt   = RUN_ONE;
            state_nxt = ST_TRACK;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_HUNT;
      run     <= '0;
      ref_idx <= '0;
      Q_out   <= '0;
      q_valid <= 1'b0;
      err     <= 1'b0;
      wrap    <= 1'b0;
      err_cnt <= '0;
    end else begin
      q_valid <= en;
      err     <= err_hit;
      wrap    <= wrap_hit;
      state   <= state_nxt;
      run     <= run_nxt;
      ref_idx <= ref_nxt;
      if (en) Q_out <= dec_idx;
      if (err_hit && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_bagua_yinyang_rx.sv
// tb/tb_bagua_yinyang_rx.sv - scoreboard bench for bagua_yinyang_rx
module tb_bagua_yinyang_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [2:0] P_in = 3'b000;
  logic [2:0] Q_out;
  logic       q_valid, lock, err, wrap;
  logic [7:0] err_cnt;

  bagua_yinyang_rx dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .P_in    (P_in),
    .Q_out   (Q_out),
    .q_valid (q_valid),
    .lock    (lock),
    .err     (err),
    .wrap    (wrap),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int q;
    int lk;
    int er;
    int wr;
    int cnt;
  } exp_t;

  exp_t sb[$];
  exp_t got;
  int   n_checks = 0;
  int   n_errors = 0;
  int   wrap_seen = 0;

  // index -> trigram (this mapping happens to be its own inverse)
  int enc_lut[8] = '{7, 3, 5, 1, 6, 2, 4, 0};

  // reference model: 0 hunt, 1 track, 2 locked, 3 suspect
  int m_state = 0, m_run = 0, m_ref = 0, m_cnt = 0;

  task automatic chk(input string tag, input int obs, input int expv);
    n_checks++;
    if (obs != expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic send(input int idx);
    int   e;
    int   er;
    int   wr;
    exp_t x;
    @(posedge clk);
    #1;
    P_in = 3'(enc_lut[idx % 8]);
    en   = 1'b1;
    e  = (m_ref + 1) % 8;
    er = 0;
    wr = 0;
    if (m_state == 0) begin
      m_ref = idx; m_run = 1; m_state = 1;
    end else if (m_state == 1) begin
      if (idx == e) begin
        m_run++;
        if (m_run >= 4) m_state = 2;
      end else begin
        m_run = 1;
      end
      m_ref = idx;
    end else if (m_state == 2) begin
      if (idx == e) begin
        m_ref = idx; wr = (e == 0);
      end else begin
        er = 1; m_ref = e; m_state = 3;
      end
    end else begin
      if (idx == e) begin
        m_ref = idx; wr = (e == 0); m_state = 2;
      end else begin
        er = 1; m_ref = idx; m_run = 1; m_state = 1;
      end
    end
    if (er != 0 && m_cnt < 255) m_cnt++;
    x.q   = idx;
    x.lk  = (m_state >= 2) ? 1 : 0;
    x.er  = er;
    x.wr  = wr;
    x.cnt = m_cnt;
    sb.push_back(x);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    en   = 1'b0;
    P_in = 3'($urandom_range(0, 7));
  endtask

  task automatic drain();
    idle();
    idle();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    en    = 1'b1;
    P_in  = 3'b101;
    @(posedge clk);
    #1;
    chk("rst_q_out", int'(Q_out), 0);
    chk("rst_q_valid", int'(q_valid), 0);
    chk("rst_lock", int'(lock), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_wrap", int'(wrap), 0);
    chk("rst_err_cnt", int'(err_cnt), 0);
    rst_n = 1'b1;
    en    = 1'b0;
    m_state = 0; m_run = 0; m_ref = 0; m_cnt = 0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (q_valid) begin
        if (sb.size() == 0) begin
          chk("spurious_q_valid", 1, 0);
        end else begin
          got = sb.pop_front();
          chk("q_out", int'(Q_out), got.q);
          chk("lock", int'(lock), got.lk);
          chk("err", int'(err), got.er);
          chk("wrap", int'(wrap), got.wr);
          chk("err_cnt", int'(err_cnt), got.cnt);
        end
      end else begin
        chk("idle_err", int'(err), 0);
        chk("idle_wrap", int'(wrap), 0);
      end
      if (wrap) wrap_seen++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    do_reset();

    // acquire
    for (int i = 0; i < 4; i++) send(i);
    drain();
    chk("lock_after_4", int'(lock), 1);
    chk("cnt_after_acq", int'(err_cnt), 0);

    // wrap through 7 -> 0
    for (int i = 4; i <= 8; i++) send(i % 8);
    drain();
    chk("wrap_once", wrap_seen, 1);

    // single miss flywheels
    send(1); send(2); send(7); send(4); send(5); send(6);
    drain();
    chk("single_miss_lock", int'(lock), 1);
    chk("single_miss_cnt", int'(err_cnt), 1);

    // double miss drops lock, then relock
    send(2); send(2);
    drain();
    chk("double_miss_unlock", int'(lock), 0);
    chk("double_miss_cnt", int'(err_cnt), 3);
    for (int i = 3; i <= 6; i++) send(i);
    drain();
    chk("relock", int'(lock), 1);

    // strobed stream
    for (int i = 7; i <= 10; i++) begin
      send(i % 8);
      idle();
    end
    drain();
    chk("strobed_wrap", wrap_seen, 2);
    chk("strobed_lock", int'(lock), 1);

    // drive err_cnt into saturation
    for (int k = 0; k < 150; k++) begin
      int x;
      x = m_ref;
      send((x + 3) % 8);
      send((x + 6) % 8);
      send((x + 7) % 8);
      send((x + 8) % 8);
      send((x + 9) % 8);
    end
    drain();
    chk("err_cnt_sat", int'(err_cnt), 255);
    chk("sat_lock", int'(lock), 1);

    do_reset();
    drain();
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
